// File: rtl/rx_control.sv
// rtl/rx_control.sv - UART receive sequencer: start-bit validation, mid-bit strobes, frame-done pulse
module rx_control #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SDI,
    input  logic [CNT_W-1:0] k,
    input  logic             bit8,
    input  logic             pen,
    output logic             btu,
    output logic             start,
    output logic             done,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bc_q, bc_d;
    logic [CNT_W-1:0] target;
    logic [3:0]       fc_q, fc_d;
    logic [3:0]       n_q, n_d;
    logic             done_q, done_d;

    assign done = done_q;

    always_comb begin
        busy    = (state_q != IDLE);
        start   = (state_q == START);
        // Half a bit time lands the strobe mid-bit; whole bit times keep it there.
        target  = start ? ((k >> 1) - CNT_W'(1)) : (k - CNT_W'(1));
        btu     = busy && (bc_q == target);
        bc_d    = (busy && !btu) ? bc_q + CNT_W'(1) : '0;
        state_d = state_q;
        fc_d    = fc_q;
        n_d     = n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                fc_d = '0;
                if (!SDI) state_d = START;
            end
            START: begin
                if (btu) begin
                    if (!SDI) begin
                        state_d = DATA;
                        n_d     = 4'd8 + {3'b0, bit8} + {3'b0, pen};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (btu) begin
                    fc_d = fc_q + 4'd1;
                    if (fc_q == n_q - 4'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bc_q    <= '0;
            fc_q    <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            fc_q    <= fc_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end
endmodule
